phase_timer: RTL
================

Name: phase_timer

Overview:
- Interval timer that paces the traffic-light sequencer in the intersection controller.
- Consumes the sequencer's per-state duration, `secondsToCount` (16-bit, whole seconds), counts it out against the 10 kHz system clock, and returns a one-cycle `finished` strobe that advances the sequencer to its next light state.
- Sits directly downstream of the sequencer's duration output and upstream of its `finished` input, closing the loop.

Parameters:
- CLK_HZ, 10000, clk cycles per second; prescaler terminal count is CLK_HZ-1; must be ≥ 2.
- SEC_W, 16, width of `secondsToCount` and of the internal seconds counter.

Ports:
- clk  input  1  system clock, 10 kHz nominal.
- reset  input  1  synchronous, active-low reset.
- enable_general  input  1  system enable; 0 forces the timer idle.
- secondsToCount  input  SEC_W  duration of the next phase in seconds; sampled only in LOAD.
- finished  output  1  phase-complete strobe to the sequencer.
- busy  output  1  high while in COUNT.
- seconds_left  output  SEC_W  remaining whole seconds of the current phase, for the display/debug path.

Behaviour:
- All outputs are registered.
- Reset (reset=0 at a clk edge):
  - state=IDLE, prescaler=0, sec_cnt=0, dur=0.
  - finished=1, busy=0, seconds_left=0.
  - Reset has priority over everything, including mid-COUNT.
- States and transitions:
  - IDLE: finished=1 (level, so the sequencer can apply its OFF/initial state); busy=0. If enable_general=1, go to LOAD.
  - LOAD: finished=0. Latch dur=secondsToCount, which the sequencer wrote on the previous edge. Clear prescaler and sec_cnt. Go to DONE if secondsToCount==0, else go to COUNT. seconds_left=secondsToCount.
  - COUNT: busy=1.
    - prescaler increments each cycle and wraps at CLK_HZ-1; on wrap, sec_cnt increments.
    - seconds_left = dur - sec_cnt, updated the cycle after each wrap.
    - When prescaler==CLK_HZ-1 and sec_cnt==dur-1, go to DONE.
  - DONE: finished=1 for exactly one cycle; busy=0; seconds_left=0. Go to LOAD.
- Timing:
  - With LOAD at cycle t0 and N>0, finished is high exactly at cycle t0+1+N*CLK_HZ.
  - With N=0, finished is high at t0+1.
  - DONE→LOAD→... gives a period of N*CLK_HZ+2 cycles per phase.
- Handshake: the sequencer acts on the edge where finished=1 and updates secondsToCount on that same edge. The timer samples secondsToCount on the following edge, in LOAD.
- Changes to secondsToCount outside LOAD are ignored.
- enable_general=0 in any state: next state is IDLE, counters cleared, finished=1, busy=0, seconds_left=0.
- enable_general re-asserted while in IDLE: one more edge with finished=1 (the sequencer consumes it), then LOAD.
- Width rules:
  - dur - sec_cnt never underflows because sec_cnt < dur while in COUNT.
  - dur=2^SEC_W-1 must count fully with no wrap.
  - Prescaler width is $clog2(CLK_HZ).

Optional Feature:
- Macro: PHASE_TIMER_PAUSE_EN.
- Defined:
  - Adds input port `pause` (1 bit).
  - While pause=1 in COUNT, prescaler and sec_cnt hold, busy stays 1 and finished stays 0.
  - pause has no effect in IDLE, LOAD or DONE.
  - enable_general=0 and reset still override pause.
- Undefined: no `pause` port; COUNT always advances.

Test Plan:
- CLK_HZ=4. Release reset with enable_general=1 and secondsToCount=3 driven before the LOAD edge → finished=1 during reset and the first cycle, LOAD at t0, finished pulses only at t0+13; seconds_left steps 3,2,1, then 0 at DONE.
- secondsToCount=0 presented at LOAD → finished pulses at t0+1, then LOAD again at t0+2.
- Back-to-back phases 17,3,1 (CLK_HZ=4) → finished pulses separated by 70, 14 and 6 cycles, each exactly one cycle wide.
- secondsToCount changed from 5 to 9 mid-COUNT → pulse still occurs at t0+1+5*CLK_HZ.
- enable_general dropped 7 cycles into a 3 s count → next cycle IDLE, finished=1, busy=0, seconds_left=0. Re-enable → LOAD one cycle later and the count restarts from zero.
- reset=0 for one cycle mid-COUNT → all outputs take their reset values on that edge. With PHASE_TIMER_PAUSE_EN defined, pause=1 for 5 cycles during a 2 s count (CLK_HZ=4) → finished is delayed to t0+1+8+5.

Source files
------------

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : phase_timer
// Purpose  : Interval timer for the traffic-light sequencer. Loads a phase
//            duration in whole seconds, counts it out against the system
//            clock and returns a one-cycle 'finished' strobe. It returns a
//            'finished' level while idle or disabled.
// Ports    : clk            - system clock (CLK_HZ cycles per second)
//            reset          - synchronous, active-low reset
//            enable_general - system enable, 0 forces the timer idle
//            secondsToCount - duration of the next phase, sampled in LOAD
//            pause          - (PHASE_TIMER_PAUSE_EN only) freezes COUNT
//            finished       - phase-complete strobe / idle level
//            busy           - high while counting
//            seconds_left   - remaining whole seconds of the current phase
// Options  : define PHASE_TIMER_PAUSE_EN to add the 'pause' input.
// Revision : 1.0 - initial release
// ============================================================================
module phase_timer #(
  parameter int CLK_HZ = 10000,
  parameter int SEC_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_general,
  input  logic [SEC_W-1:0] secondsToCount,
`ifdef PHASE_TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic             finished,
  output logic             busy,
  output logic [SEC_W-1:0] seconds_left
);

  localparam int              PS_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PS_W-1:0]  ps_q,    ps_d;
  logic [SEC_W-1:0] sec_q,   sec_d;
  logic [SEC_W-1:0] dur_q,   dur_d;
  logic             fin_q,   fin_d;
  logic             busy_q,  busy_d;
  logic [SEC_W-1:0] left_q,  left_d;
  logic             count_hold;

`ifdef PHASE_TIMER_PAUSE_EN
  assign count_hold = pause;
`else
  assign count_hold = 1'b0;
`endif

  // Outputs are registered: each *_d below is the value the output takes
  // while the FSM sits in state_d.
  always_comb begin
    state_d = state_q;
    ps_d    = ps_q;
    sec_d   = sec_q;
    dur_d   = dur_q;
    fin_d   = 1'b0;
    busy_d  = 1'b0;
    left_d  = left_q;

    if (!enable_general) begin
      state_d = S_IDLE;
      ps_d    = '0;
      sec_d   = '0;
      dur_d   = '0;
      fin_d   = 1'b1;
      left_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_LOAD;
          left_d  = '0;
        end

        S_LOAD: begin
          dur_d  = secondsToCount;
          ps_d   = '0;
          sec_d  = '0;
          left_d = secondsToCount;
          if (secondsToCount == '0) begin
            state_d = S_DONE;
            fin_d   = 1'b1;
          end else begin
            state_d = S_COUNT;
            busy_d  = 1'b1;
          end
        end

        S_COUNT: begin
          busy_d = 1'b1;
          if (!count_hold) begin
            if (ps_q == PS_MAX) begin
              ps_d = '0;
              // sec_q < dur_q always holds here, so the last second is
              // recognised one step early and sec_q never reaches dur_q.
              if (sec_q == dur_q - SEC_W'(1)) begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                fin_d   = 1'b1;
                left_d  = '0;
              end else begin
                sec_d  = sec_q + SEC_W'(1);
                left_d = dur_q - (sec_q + SEC_W'(1));
              end
            end else begin
              ps_d = ps_q + PS_W'(1);
            end
          end
        end

        S_DONE: begin
          state_d = S_LOAD;
          left_d  = '0;
        end

        default: begin
          state_d = S_IDLE;
          fin_d   = 1'b1;
          left_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ps_q    <= '0;
      sec_q   <= '0;
      dur_q   <= '0;
      fin_q   <= 1'b1;
      busy_q  <= 1'b0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      sec_q   <= sec_d;
      dur_q   <= dur_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
      left_q  <= left_d;
    end
  end

  assign finished     = fin_q;
  assign busy         = busy_q;
  assign seconds_left = left_q;

endmodule
`default_nettype wire
